// File: rtl/wisc_pkg.sv
// Shared constants for the WISC pipeline: forwarding-mux selects, the
// hard-wired zero register and the load opcode.
package wisc_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [3:0] REG_ZERO = 4'd0;

  localparam logic [3:0] OP_LW = 4'b1000;

endpackage

// File: rtl/fwd_sel.sv
// Per-source priority compare of one read address against the EX and MEM
// shadow entries; the EX (newer) producer always wins over MEM.
module fwd_sel
  import wisc_pkg::*;
#(
  parameter int RF_AW = 4
) (
  input  logic             rd_i,
  input  logic [RF_AW-1:0] addr_i,
  input  logic [RF_AW-1:0] ex_dst_i,
  input  logic             ex_we_i,
  input  logic             ex_ld_i,
  input  logic [RF_AW-1:0] mem_dst_i,
  input  logic             mem_we_i,
  output logic [1:0]       sel_o,
  output logic             ld_hit_o
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = rd_i && ex_we_i  && (addr_i == ex_dst_i);
  assign mem_hit = rd_i && mem_we_i && (addr_i == mem_dst_i);

  // A load in EX still shadows an older MEM writer; the top stalls instead.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit) begin
      sel_o = ex_ld_i ? FWD_RF : FWD_MEM;
    end else if (mem_hit) begin
      sel_o = FWD_WB;
    end
  end

  assign ld_hit_o = ex_hit && ex_ld_i;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select, load-use stall and branch-flush generator for the
// 5-stage WISC pipeline, with saturating stall/forward event counters.
module fwd_hazard_unit
  import wisc_pkg::*;
#(
  parameter int RF_AW = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_re0,
  input  logic             id_re1,
  input  logic [RF_AW-1:0] id_p0_addr,
  input  logic [RF_AW-1:0] id_p1_addr,
  input  logic [RF_AW-1:0] id_dst_addr,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             br_ctrl,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  localparam logic [RF_AW-1:0] ZERO_ADDR = RF_AW'(REG_ZERO);

  logic [RF_AW-1:0] ex_dst_q, ex_dst_d;
  logic             ex_we_q, ex_we_d;
  logic             ex_ld_q, ex_ld_d;
  logic [RF_AW-1:0] mem_dst_q, mem_dst_d;
  logic             mem_we_q, mem_we_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  logic       rd_p0, rd_p1;
  logic [1:0] sel_p0, sel_p1;
  logic       hit_p0, hit_p1;
  logic       bubble;

  assign rd_p0 = id_valid && id_re0 && (id_p0_addr != ZERO_ADDR);
  assign rd_p1 = id_valid && id_re1 && (id_p1_addr != ZERO_ADDR);

  fwd_sel #(.RF_AW(RF_AW)) u_sel_p0 (
    .rd_i      (rd_p0),
    .addr_i    (id_p0_addr),
    .ex_dst_i  (ex_dst_q),
    .ex_we_i   (ex_we_q),
    .ex_ld_i   (ex_ld_q),
    .mem_dst_i (mem_dst_q),
    .mem_we_i  (mem_we_q),
    .sel_o     (sel_p0),
    .ld_hit_o  (hit_p0)
  );

  fwd_sel #(.RF_AW(RF_AW)) u_sel_p1 (
    .rd_i      (rd_p1),
    .addr_i    (id_p1_addr),
    .ex_dst_i  (ex_dst_q),
    .ex_we_i   (ex_we_q),
    .ex_ld_i   (ex_ld_q),
    .mem_dst_i (mem_dst_q),
    .mem_we_i  (mem_we_q),
    .sel_o     (sel_p1),
    .ld_hit_o  (hit_p1)
  );

  // Flush wins over stall; either one injects a bubble into EX.
  assign flush  = br_ctrl;
  assign stall  = (hit_p0 || hit_p1) && !br_ctrl && !rst;
  assign bubble = hit_p0 || hit_p1 || br_ctrl;

  always_comb begin
    mem_dst_d   = ex_dst_q;
    mem_we_d    = ex_we_q;
    ex_dst_d    = id_dst_addr;
    ex_we_d     = id_valid && id_we;
    ex_ld_d     = id_valid && id_is_load;
    fwd_a_d     = sel_p1;
    fwd_b_d     = sel_p0;
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;

    if (bubble) begin
      ex_dst_d = ZERO_ADDR;
      ex_we_d  = 1'b0;
      ex_ld_d  = 1'b0;
      fwd_a_d  = FWD_RF;
      fwd_b_d  = FWD_RF;
    end

    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (((fwd_a_q != FWD_RF) || (fwd_b_q != FWD_RF)) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dst_q    <= ZERO_ADDR;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_dst_q   <= ZERO_ADDR;
      mem_we_q    <= 1'b0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      ex_dst_q    <= ex_dst_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      mem_dst_q   <= mem_dst_d;
      mem_we_q    <= mem_we_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign forwardA  = fwd_a_q;
  assign forwardB  = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios with literal
// expectations, then randomized traffic against an in-flight instruction model.
module tb_fwd_hazard_unit;

  localparam int AW     = 4;
  localparam int CW     = 8;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_re0, id_re1, id_we, id_is_load, br_ctrl;
  logic [AW-1:0] id_p0_addr, id_p1_addr, id_dst_addr;
  logic [1:0]    forwardA, forwardB;
  logic          stall, flush;
  logic [CW-1:0] stall_cnt, fwd_cnt;

  fwd_hazard_unit #(.RF_AW(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_re0      (id_re0),
    .id_re1      (id_re1),
    .id_p0_addr  (id_p0_addr),
    .id_p1_addr  (id_p1_addr),
    .id_dst_addr (id_dst_addr),
    .id_we       (id_we),
    .id_is_load  (id_is_load),
    .br_ctrl     (br_ctrl),
    .forwardA    (forwardA),
    .forwardB    (forwardB),
    .stall       (stall),
    .flush       (flush),
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
  );

  initial forever #5 clk = ~clk;

  // In-flight instructions ahead of ID: slot 0 is one stage ahead, slot 1 two.
  typedef struct {
    bit wr;
    bit ld;
    int dst;
  } rec_t;

  rec_t fl[2];
  int   m_fa, m_fb, m_scnt, m_fcnt;
  bit   m_ok;
  int   checks;
  int   failures;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Which stage must supply operand 'addr' for the ID instruction; lu flags
  // that the newest in-flight writer is a load still one stage ahead.
  function automatic int src_eval(input bit re, input int addr, output bit lu);
    lu = 1'b0;
    if (!id_valid || !re || addr == 0) return 0;
    for (int d = 0; d < 2; d++) begin
      if (fl[d].wr && fl[d].dst == addr) begin
        if (d == 0 && fl[d].ld) begin
          lu = 1'b1;
          return 0;
        end
        return (d == 0) ? 2 : 1;
      end
    end
    return 0;
  endfunction

  function automatic bit model_stall();
    bit l0, l1;
    int s0, s1;
    s0 = src_eval(id_re0, int'(id_p0_addr), l0);
    s1 = src_eval(id_re1, int'(id_p1_addr), l1);
    return !rst && !br_ctrl && (l0 || l1) && (s0 >= 0) && (s1 >= 0);
  endfunction

  task automatic model_edge();
    bit l0, l1, bub, st;
    int s0, s1;
    if (rst) begin
      fl[0] = '{wr: 1'b0, ld: 1'b0, dst: 0};
      fl[1] = '{wr: 1'b0, ld: 1'b0, dst: 0};
      m_fa = 0; m_fb = 0; m_scnt = 0; m_fcnt = 0;
      m_ok = 1'b1;
      return;
    end
    s0  = src_eval(id_re0, int'(id_p0_addr), l0);
    s1  = src_eval(id_re1, int'(id_p1_addr), l1);
    st  = (l0 || l1) && !br_ctrl;
    bub = l0 || l1 || br_ctrl;
    if ((m_fa != 0 || m_fb != 0) && m_fcnt < CNTMAX) m_fcnt++;
    if (st && m_scnt < CNTMAX) m_scnt++;
    fl[1] = fl[0];
    if (bub) fl[0] = '{wr: 1'b0, ld: 1'b0, dst: 0};
    else fl[0] = '{wr: id_valid && id_we, ld: id_valid && id_is_load, dst: int'(id_dst_addr)};
    m_fa = bub ? 0 : s1;
    m_fb = bub ? 0 : s0;
  endtask

  // One clock: compare everything at the falling edge, advance model at the rising edge.
  task automatic step();
    @(negedge clk);
    if (m_ok) begin
      chk("stall", int'(stall), int'(model_stall()));
      chk("flush", int'(flush), int'(br_ctrl));
      chk("forwardA", int'(forwardA), m_fa);
      chk("forwardB", int'(forwardB), m_fb);
      chk("stall_cnt", int'(stall_cnt), m_scnt);
      chk("fwd_cnt", int'(fwd_cnt), m_fcnt);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_id(input bit v, input bit r0, input int p0, input bit r1, input int p1,
                        input bit we, input int dst, input bit ld);
    id_valid    = v;
    id_re0      = r0;
    id_p0_addr  = AW'(p0);
    id_re1      = r1;
    id_p1_addr  = AW'(p1);
    id_we       = we;
    id_dst_addr = AW'(dst);
    id_is_load  = ld;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; m_ok = 1'b0;
    br_ctrl = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    chk("reset_fA", int'(forwardA), 0);
    chk("reset_fB", int'(forwardB), 0);
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    chk("reset_fwd_cnt", int'(fwd_cnt), 0);

    // ADD R3,R1,R2 ; SUB R4,R3,R5
    set_id(1, 1, 1, 1, 2, 1, 3, 0); step();
    set_id(1, 1, 3, 1, 5, 1, 4, 0); step();
    chk("ex_dist_fB", int'(forwardB), 2);
    chk("ex_dist_fA", int'(forwardA), 0);

    // ADD R3 ; unrelated ; reader of R3 on p1, then on both
    set_id(1, 1, 1, 1, 2, 1, 3, 0);   step();
    set_id(1, 1, 9, 1, 10, 1, 8, 0);  step();
    set_id(1, 1, 1, 1, 3, 1, 11, 0);  step();
    chk("mem_dist_fA", int'(forwardA), 1);
    chk("mem_dist_fB", int'(forwardB), 0);
    set_id(1, 1, 1, 1, 2, 1, 3, 0);   step();
    set_id(1, 1, 9, 1, 10, 1, 8, 0);  step();
    set_id(1, 1, 3, 1, 3, 1, 12, 0);  step();
    chk("mem_both_fA", int'(forwardA), 1);
    chk("mem_both_fB", int'(forwardB), 1);

    // LW R6 ; ADD R7,R6,R6
    do_reset();
    set_id(1, 1, 1, 0, 0, 1, 6, 1); step();
    set_id(1, 1, 6, 1, 6, 1, 7, 0); #1;
    chk("lu_stall", int'(stall), 1);
    step();
    chk("lu_bubble_fA", int'(forwardA), 0);
    chk("lu_bubble_fB", int'(forwardB), 0);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    chk("lu_stall_once", int'(stall), 0);
    step();
    chk("lu_fA", int'(forwardA), 1);
    chk("lu_fB", int'(forwardB), 1);

    // ADD R2 ; ADD R2 ; reader of R2
    set_id(1, 1, 1, 1, 5, 1, 2, 0); step();
    set_id(1, 1, 1, 1, 5, 1, 2, 0); step();
    set_id(1, 1, 1, 1, 2, 1, 9, 0); step();
    chk("prio_fA", int'(forwardA), 2);

    // write R0 ; read R0
    set_id(1, 1, 1, 1, 5, 1, 0, 0); step();
    set_id(1, 1, 0, 1, 0, 1, 9, 0); step();
    chk("r0_fA", int'(forwardA), 0);
    chk("r0_fB", int'(forwardB), 0);

    // branch flush together with a load-use
    set_id(1, 1, 1, 0, 0, 1, 6, 1); step();
    set_id(1, 1, 6, 1, 6, 1, 7, 0); br_ctrl = 1'b1; #1;
    chk("flush_stall", int'(stall), 0);
    chk("flush_flag", int'(flush), 1);
    step();
    br_ctrl = 1'b0;
    chk("flush_fA", int'(forwardA), 0);
    chk("flush_fB", int'(forwardB), 0);

    // reset asserted while a load-use stall is pending
    set_id(1, 1, 1, 0, 0, 1, 6, 1); step();
    set_id(1, 1, 6, 1, 6, 1, 7, 0); #1;
    chk("pre_rst_stall", int'(stall), 1);
    rst = 1'b1; step(); rst = 1'b0; #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_fA", int'(forwardA), 0);
    chk("rst_fB", int'(forwardB), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_fwd_cnt", int'(fwd_cnt), 0);

    // stall counter saturation
    for (int i = 0; i < CNTMAX + 40; i++) begin
      set_id(1, 1, 1, 0, 0, 1, 6, 1); step();
      set_id(1, 1, 6, 1, 6, 1, 7, 0); step(); step();
    end
    chk("sat_stall_cnt", int'(stall_cnt), CNTMAX);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 2) == 0);
      br_ctrl = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; br_ctrl = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Pipeline hazard controller that generates the `forwardA`/`forwardB` source selects consumed by the execute stage's forwarding muxes. It also generates the load-use stall and branch flush for the 5-stage WISC pipeline. It sits alongside the ID stage and keeps its own shadow copy of destination-register state for the instructions in EX and MEM. Its registered outputs are valid in the same cycle the matching instruction occupies EX.

## Interface
- `RF_AW`, default 4: register address width (16 registers, R0 reads as zero).
- `CNT_W`, default 16: width of the saturating performance counters.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  a real instruction is present in ID (not a bubble).
- `id_re0`, `id_re1`  in  1 each  the ID instruction reads `p0` / `p1`.
- `id_p0_addr`, `id_p1_addr`  in  RF_AW each  source register addresses.
- `id_dst_addr`  in  RF_AW  destination register address.
- `id_we`  in  1  the ID instruction writes the register file.
- `id_is_load`  in  1  the ID instruction is LW; its data is available only at WB.
- `br_ctrl`  in  1  taken branch resolved in EX this cycle.
- `forwardA`  out  2  select for the src1 (`p1`) mux; registered.
- `forwardB`  out  2  select for the src0 (`p0`) mux; registered.
- `stall`  out  1  combinational; hold PC and IF/ID, inject a bubble into ID/EX.
- `flush`  out  1  combinational; equals `br_ctrl`; squash IF/ID and ID/EX.
- `stall_cnt`, `fwd_cnt`  out  CNT_W each  saturating event counters.

## Operation
- **Shadow pipeline.** Holds `ex_{dst,we,ld}` for the instruction now in EX and `mem_{dst,we}` for the instruction now in MEM. Each cycle, EX advances to MEM, and ID advances to EX unless a bubble is injected.
- **Bubble.** Loads `we=0, ld=0` into the EX entry.
- **Qualified read.** Source s is considered only when `id_valid & id_re_s & addr_s != 0`.
- **Forward encoding, computed at ID and registered into EX:**
  - `2'b10` if s matches `ex_dst` with `ex_we` and `!ex_ld`. The producer will be in MEM, so forward `alu_result_MEM_WB`.
  - else `2'b01` if s matches `mem_dst` with `mem_we`. The producer will be in WB, so forward `wb_data_WB`.
  - else `2'b00`.
  - The newer producer always wins, so `2'b11` is never produced.
- **Register-file distance.** A producer in WB while the consumer is in ID needs no forwarding; the register file resolves same-cycle write/read.
- **Load-use.** `stall=1` when a qualified source matches `ex_dst` with `ex_we & ex_ld`.
  - During the stall the EX entry takes a bubble and `forwardA`/`forwardB` register `2'b00`.
  - The next cycle the load is in MEM and the same ID instruction is re-evaluated, yielding `2'b01`.
- **Flush.** `br_ctrl=1` puts a bubble into the EX entry, loads `2'b00` into the forward registers, and forces `stall=0`; flush overrides stall. The MEM entry still advances from EX, since the branch itself completes.
- **Counters.**
  - `stall_cnt` increments once per cycle in which `stall` is high.
  - `fwd_cnt` increments once per cycle in which either registered select is nonzero.
  - Both saturate at all-ones.

## Timing
- **Reset.** Assertion on an edge clears all shadow entries (`we=0`, `ld=0`, `dst=0`), `forwardA=forwardB=2'b00`, and both counters. `stall` and `flush` read 0 from the first cycle after reset, provided `br_ctrl=0`.
- **Reset mid-stall.** Reset overrides stall and flush, so no residual stall remains after reset.
- **Latency.**
  - The forward select is registered one cycle after ID evaluation, aligned with the instruction's EX cycle.
  - `stall` and `flush` are same-cycle combinational.
- **Stall length.**
  - A load-use hazard costs exactly one cycle.
  - Back-to-back loads to different registers do not stall.
- **Simultaneous events.**
  - A load-use match on both sources still gives a single one-cycle stall.
  - `br_ctrl` together with a load-use gives no stall, and the ID instruction is discarded.
- **R0.** Never matches, even when a producer writes R0.

## Structure
- Shared package `wisc_pkg`:
  - `FWD_RF=2'b00`, `FWD_WB=2'b01`, `FWD_MEM=2'b10`.
  - `REG_ZERO=4'd0`.
  - The `LW` opcode constant.
- Sub-module `fwd_sel`: combinational per-source priority compare of one address against the EX and MEM shadow entries. It returns a 2-bit select and a load-hit flag and is instantiated twice.
- The top level holds the shadow registers, the forward registers, stall/flush logic, and the counters.

## Test plan
- **EX-distance forwarding.** `ADD R3,R1,R2` followed by `SUB R4,R3,R5` → in the SUB's EX cycle, `forwardB=2'b10` and `forwardA=2'b00`.
- **MEM-distance forwarding.** `ADD R3`, then an unrelated instruction, then a reader of R3 on `p1` → `forwardA=2'b01`. The same case with R3 on both sources → both selects are `2'b01`, never `2'b11`.
- **Load-use.** `LW R6` followed by `ADD R7,R6,R6` → `stall=1` for exactly one cycle, a bubble goes to EX, then both forward selects are `2'b01`; `stall_cnt` increments from 0 to 1.
- **Priority.** `ADD R2`, then `ADD R2`, then a reader of R2 → select is `2'b10`, taken from the newer producer.
- **R0 and flush.** A write to R0 followed by a reader of R0 → `2'b00`. Separately, `br_ctrl=1` in the same cycle as a load-use → `stall=0`, `flush=1`, and the next cycle's selects are `2'b00`.
- **Reset and saturation.** Assert `rst` mid-stall → all outputs are 0 on the next cycle. Force more than 65535 stalls → `stall_cnt` holds at 16'hFFFF.
